// File: rtl/lifo_arbiter.sv
// Two-client shared 8-entry LIFO with round-robin arbitration and per-client handshakes.
// Define LIFO_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
module lifo_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_data,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_count;
  logic                r_owner;
  logic                r_op;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_stack [DEPTH];

  logic                w_win;
  logic                w_take;
  logic                w_rsp_acc;
  logic                w_full;
  logic                w_empty;
  logic                w_do_push;
  logic                w_do_pop;
  logic [CNT_W-1:0]    w_cnt_m1;
  logic [AW-1:0]       w_wr_idx;
  logic [AW-1:0]       w_rd_idx;

`ifdef LIFO_ARB_FIXED_PRIO_EN
  assign w_win = ~req_valid[0];
`else
  logic r_last_grant;
  // Tie goes to the client that did not win last time.
  assign w_win = (req_valid == 2'b11) ? ~r_last_grant
                                      : req_valid[1];
`endif

  assign w_take    = (r_state == S_IDLE) && (|req_valid);
  assign w_rsp_acc = (r_state == S_RESP) && rsp_ready[r_owner];
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = (r_state == S_EXEC) && r_op && !w_full;
  assign w_do_pop  = (r_state == S_EXEC) && !r_op && !w_empty;
  assign w_cnt_m1  = r_count - CNT_W'(1);
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_rd_idx  = w_cnt_m1[AW-1:0];

  always_comb begin
    req_ready = 2'b00;
    if (w_take) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_rsp_acc) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_owner     <= 1'b0;
      r_op        <= 1'b0;
      r_data      <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      if (w_take) begin
        r_owner <= w_win;
        r_op    <= req_op[w_win];
        r_data  <= w_win ? req_data[2*DATA_W-1:DATA_W]
                         : req_data[DATA_W-1:0];
`ifndef LIFO_ARB_FIXED_PRIO_EN
        r_last_grant <= w_win;
`endif
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_err  <= r_op ? w_full : w_empty;
        r_rsp_data <= w_do_pop ? r_stack[w_rd_idx] : '0;
        if (w_do_push)     r_count <= r_count + CNT_W'(1);
        else if (w_do_pop) r_count <= w_cnt_m1;
      end
      if (w_rsp_acc) r_rsp_valid <= 2'b00;
    end
  end

  // Storage needs no reset; contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_stack[w_wr_idx] <= r_data;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed + randomized bench for lifo_arbiter against a queue-based model.
// Honours LIFO_ARB_FIXED_PRIO_EN for the tie-break expectation.
module tb_lifo_arbiter;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op;
  logic [2*DW-1:0] req_data;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          busy;

  lifo_arbiter #(.DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .empty(empty), .full(full), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q[$];
  int lg;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    int w;
    if (v == 2'b01) w = 0;
    else if (v == 2'b10) w = 1;
`ifdef LIFO_ARB_FIXED_PRIO_EN
    else w = 0;
`else
    else w = (lg == 1) ? 0 : 1;
`endif
    return w;
  endfunction

  // Starts just after a negedge with the DUT idle; ends the same way.
  task automatic run_op(input int c, input bit push, input logic [7:0] d,
                        input int hold, input bit raise_other);
    logic [7:0] ed;
    logic       ee;
    logic [1:0] oh;
    logic [1:0] ooh;
    oh  = (c == 0) ? 2'b01 : 2'b10;
    ooh = ~oh;
    ee  = 1'b0;
    ed  = 8'h00;
    if (push) begin
      if (q.size() == D) ee = 1'b1;
      else q.push_back(d);
    end else begin
      if (q.size() == 0) ee = 1'b1;
      else ed = q.pop_back();
    end
    req_valid[c] = 1'b1;
    req_op[c]    = push;
    req_data[c*DW +: DW] = d;
    #1 chk("req_ready", req_ready, oh);
    lg = c;
    @(posedge clk);
    @(negedge clk);
    req_valid[c] = 1'b0;
    if (raise_other) begin
      req_valid[1-c] = 1'b1;
      req_op[1-c]    = 1'b1;
      req_data[(1-c)*DW +: DW] = 8'h5A;
    end
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_data", rsp_data, ed);
    chk("count", count, q.size());
    chk("full", full, q.size() == D);
    chk("empty", empty, q.size() == 0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready[1-c] = 1'b1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, oh);
      chk("hold_data", rsp_data, ed);
      chk("hold_busy", busy, 1);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready[1-c] = 1'b0;
    rsp_ready[c]   = 1'b1;
    @(negedge clk);
    rsp_ready[c] = 1'b0;
    chk("acc_rsp_valid", rsp_valid, 0);
    chk("acc_busy", busy, 0);
    if (raise_other) chk("next_grant", req_ready, ooh);
  endtask

  initial begin
    logic [1:0] w1h;
    int w;
    reset = 1'b1;
    req_valid = 2'b00;
    req_op = 2'b00;
    req_data = '0;
    rsp_ready = 2'b00;
    lg = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);

    for (int i = 1; i <= 8; i++)
      run_op(0, 1'b1, 8'(i * 8'h11), 0, 1'b0);
    run_op(1, 1'b1, 8'h99, 0, 1'b0);
    for (int i = 0; i < 9; i++)
      run_op(1, 1'b0, 8'h00, 0, 1'b0);

    req_valid = 2'b11;
    req_op    = 2'b11;
    req_data  = {8'hB1, 8'hA0};
    for (int k = 0; k < 4; k++) begin
      #1;
      w = pick(req_valid);
      w1h = (w == 0) ? 2'b01 : 2'b10;
      chk("arb_grant", req_ready, w1h);
      lg = w;
      q.push_back((w == 1) ? 8'hB1 : 8'hA0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("arb_rsp_valid", rsp_valid, w1h);
      chk("arb_rsp_err", rsp_err, 0);
      chk("arb_count", count, q.size());
      rsp_ready = 2'b11;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;

    run_op(0, 1'b1, 8'h42, 0, 1'b0);
    run_op(0, 1'b0, 8'h00, 5, 1'b1);
    run_op(1, 1'b1, 8'h5A, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 1), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    lg = 1;
    run_op(0, 1'b1, 8'h01, 0, 1'b0);
    run_op(1, 1'b1, 8'h02, 0, 1'b0);
    req_valid[0] = 1'b1;
    req_op[0]    = 1'b1;
    req_data[7:0] = 8'h03;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", rsp_valid, 2'b01);
    chk("pre_rst_count", count, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    lg = 1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    run_op(0, 1'b0, 8'h00, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shared 8-entry LIFO that two requesters (client 0 and client 1) access through per-client valid/ready request and response handshakes.
- A round-robin arbiter picks one request at a time. A 3-state FSM runs the push or pop and returns status and data to the winning client only.
- Sits between packet-side agents and the stack storage. Stack storage is internal.

Parameters:
DATA_W, 8, data word width
DEPTH, 8, stack entries (power of two, at least 2)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
req_valid  input  2  bit i = client i has a request
req_ready  output  2  bit i = client i request accepted this cycle
req_op  input  2  bit i: 1 = push, 0 = pop, for client i
req_data  input  2*DATA_W  client i push data at [i*DATA_W +: DATA_W]
rsp_valid  output  2  bit i = response pending for client i
rsp_ready  input  2  bit i = client i takes the response
rsp_data  output  DATA_W  popped word (0 for push or error)
rsp_err  output  1  1 = push on full or pop on empty
count  output  CNT_W  current occupancy
empty  output  1  count==0, decoded from registered count, no lag
full  output  1  count==DEPTH, same timing as empty
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - FSM=IDLE, count=0, rsp_valid=0, rsp_data=0, rsp_err=0, last_grant=1 (client 0 wins the first tie).
  - Storage contents are don't-care.
  - Reset has priority over everything. A reset mid-operation aborts the op and drops any pending response.
- FSM states:
  - IDLE:
    - req_ready is combinational: only the winner's bit is 1, and only when at least one req_valid is set.
    - Winner: the only requester; on a tie, the client that is not last_grant.
    - On handshake, capture owner, op and data, update last_grant, go to EXEC.
    - req_ready=0 in every other state.
  - EXEC (1 cycle):
    - Push with count<DEPTH: stack[count]<=data, count+1, err=0, rsp_data=0.
    - Push with count==DEPTH: no write, err=1, rsp_data=0.
    - Pop with count>0: rsp_data<=stack[count-1], count-1, err=0.
    - Pop with count==0: err=1, rsp_data=0.
    - Set rsp_valid[owner]=1, go to RESP.
  - RESP:
    - Hold rsp_valid[owner], rsp_data and rsp_err stable until rsp_ready[owner]=1.
    - rsp_ready of the other client is ignored.
    - On acceptance: rsp_valid=0, go to IDLE.
- Latency: request handshake at cycle N, rsp_valid at N+2. Minimum 3 cycles per operation. No new grant until the response is accepted.
- Only one operation is ever in flight, so simultaneous push/pop on one stack cannot occur.
- Requests held in IDLE must keep req_op and req_data stable until req_ready.
- count never wraps: saturates at 0 and DEPTH via the error path.
- busy=1 in EXEC and RESP.

Optional Feature:
- Macro: LIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, client 0 always wins a tie. last_grant is not implemented.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- After reset, client 0 pushes 0x11, 0x22 … 0x88 (rsp_ready=1) -> each rsp has err=0; count reaches 8, full=1, empty=0; rsp_valid[0] arrives 2 cycles after each req_ready[0].
- With the stack full, client 1 pushes 0x99 -> rsp_valid[1]=1, rsp_err=1, rsp_data=0x00, count stays 8.
- Eight pops from client 1 -> rsp_data is 0x88, 0x77 … 0x11 in that order; count reaches 0, empty=1. A ninth pop -> rsp_err=1, rsp_data=0x00, count stays 0.
- Both clients hold req_valid high (push) for 4 requests -> grants alternate 0,1,0,1 (round-robin build). With LIFO_ARB_FIXED_PRIO_EN defined -> client 0 wins all four.
- Hold rsp_ready[0]=0 for 5 cycles after a pop of 0x42 -> rsp_valid[0], rsp_data=0x42 and busy held stable; req_ready=0 to client 1 throughout; client 1 is granted the cycle after acceptance.
- Assert reset for 1 cycle while in RESP with 3 entries stored -> next cycle rsp_valid=0, count=0, empty=1, busy=0; a subsequent pop returns err=1.
